// File: rtl/axi_mem_responder.sv
// axi_mem_responder: single-clock AXI4 slave backed by an on-chip word array.
// One transaction in flight at a time; every burst is walked as INCR over
// 128-bit words, with the word index wrapping at the array depth.
module axi_mem_responder #(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16,
  parameter int MEM_DEPTH_LOG2 = 12
) (
  input  logic                      i_clk,
  input  logic                      i_rst_x,
  // write address channel
  input  logic [3:0]                s_axi_awid,
  input  logic [APP_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic [1:0]                s_axi_awburst,
  input  logic                      s_axi_awlock,
  input  logic [3:0]                s_axi_awcache,
  input  logic [2:0]                s_axi_awprot,
  input  logic [3:0]                s_axi_awqos,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  // write data channel
  input  logic [APP_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [APP_MASK_WIDTH-1:0] s_axi_wstrb,
  input  logic                      s_axi_wlast,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  // write response channel
  output logic [3:0]                s_axi_bid,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  // read address channel
  input  logic [3:0]                s_axi_arid,
  input  logic [APP_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [1:0]                s_axi_arburst,
  input  logic                      s_axi_arlock,
  input  logic [3:0]                s_axi_arcache,
  input  logic [2:0]                s_axi_arprot,
  input  logic [3:0]                s_axi_arqos,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  // read data channel
  output logic [3:0]                s_axi_rid,
  output logic [APP_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready
);

  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam logic [MEM_DEPTH_LOG2-1:0] IDX_ONE = 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_WRESP,
    S_RFETCH,
    S_RDATA
  } state_t;

  state_t                    state;
  logic [MEM_DEPTH_LOG2-1:0] idx;      // current word index of the burst
  logic [7:0]                cnt;      // beats remaining after the current one
  logic [3:0]                id_q;     // id of the transaction in flight
  logic                      err_q;    // wlast seen on the wrong beat
  logic                      prio_w;   // 1: write wins a simultaneous request

  logic                      grant_w;
  logic                      w_hs;
  logic [APP_DATA_WIDTH-1:0] mem [DEPTH];
  logic [APP_DATA_WIDTH-1:0] rd_q;

  // Sideband fields and the address bits outside the word index carry no
  // meaning for this memory; fold them into one sink so nothing dangles.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awsize, s_axi_awburst, s_axi_awlock, s_axi_awcache,
                           s_axi_awprot, s_axi_awqos, s_axi_awaddr,
                           s_axi_arsize, s_axi_arburst, s_axi_arlock, s_axi_arcache,
                           s_axi_arprot, s_axi_arqos, s_axi_araddr};

  // Round-robin: a lone request always wins, a tie goes to the flagged channel.
  assign grant_w       = s_axi_awvalid && (!s_axi_arvalid || prio_w);
  // NOTE: the readies are combinational so a request is taken in the cycle it
  // appears; gating with i_rst_x keeps them low for the whole reset interval.
  assign s_axi_awready = i_rst_x && (state == S_IDLE) && grant_w;
  assign s_axi_arready = i_rst_x && (state == S_IDLE) && s_axi_arvalid && !grant_w;

  assign s_axi_wready  = (state == S_WDATA);
  assign w_hs          = s_axi_wready && s_axi_wvalid;

  assign s_axi_bvalid  = (state == S_WRESP);
  assign s_axi_bid     = id_q;
  assign s_axi_bresp   = (s_axi_bvalid && err_q) ? RESP_SLVERR : RESP_OKAY;

  assign s_axi_rvalid  = (state == S_RDATA);
  assign s_axi_rid     = id_q;
  assign s_axi_rresp   = RESP_OKAY;
  assign s_axi_rlast   = s_axi_rvalid && (cnt == 8'd0);
  // The read register is only loaded in RFETCH, so it is stable across RDATA;
  // masking by state gives a clean zero while idle and straight out of reset.
  assign s_axi_rdata   = s_axi_rvalid ? rd_q : '0;

  // Transaction sequencer: address capture, beat counting and response phases.
  always_ff @(posedge i_clk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      state  <= S_IDLE;
      idx    <= '0;
      cnt    <= '0;
      id_q   <= '0;
      err_q  <= 1'b0;
      prio_w <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (s_axi_awready) begin
            id_q   <= s_axi_awid;
            idx    <= s_axi_awaddr[MEM_DEPTH_LOG2+3:4];
            cnt    <= s_axi_awlen;
            err_q  <= 1'b0;
            prio_w <= 1'b0;
            state  <= S_WDATA;
          end else if (s_axi_arready) begin
            id_q   <= s_axi_arid;
            idx    <= s_axi_araddr[MEM_DEPTH_LOG2+3:4];
            cnt    <= s_axi_arlen;
            prio_w <= 1'b1;
            state  <= S_RFETCH;
          end
        end
        S_WDATA: begin
          if (s_axi_wvalid) begin
            if (s_axi_wlast != (cnt == 8'd0)) err_q <= 1'b1;
            idx <= idx + IDX_ONE;
            if (cnt == 8'd0) state <= S_WRESP;
            else             cnt   <= cnt - 8'd1;
          end
        end
        S_WRESP: begin
          if (s_axi_bready) state <= S_IDLE;
        end
        S_RFETCH: begin
          state <= S_RDATA;
        end
        S_RDATA: begin
          if (s_axi_rready) begin
            if (cnt == 8'd0) begin
              state <= S_IDLE;
            end else begin
              idx   <= idx + IDX_ONE;
              cnt   <= cnt - 8'd1;
              state <= S_RFETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Word array: byte-strobed write port and a registered read port.
  // NOTE: the array and its read register have no reset, which keeps them
  // mappable onto block RAM; contents after power-up are undefined.
  always_ff @(posedge i_clk) begin
    if (w_hs) begin
      for (int k = 0; k < APP_MASK_WIDTH; k++) begin
        if (s_axi_wstrb[k]) mem[idx][k*8 +: 8] <= s_axi_wdata[k*8 +: 8];
      end
    end
    if (state == S_RFETCH) rd_q <= mem[idx];
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder: directed scenarios plus randomized write/read-back
// bursts, checked against a word-array model with per-byte "written" tracking.
module tb_axi_mem_responder;

  localparam int AW    = 28;
  localparam int DW    = 128;
  localparam int MW    = 16;
  localparam int DL    = 12;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          rst_x;
  logic [3:0]    s_axi_awid, s_axi_arid;
  logic [AW-1:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0]    s_axi_awlen, s_axi_arlen;
  logic [2:0]    s_axi_awsize, s_axi_arsize, s_axi_awprot, s_axi_arprot;
  logic [1:0]    s_axi_awburst, s_axi_arburst;
  logic          s_axi_awlock, s_axi_arlock;
  logic [3:0]    s_axi_awcache, s_axi_arcache, s_axi_awqos, s_axi_arqos;
  logic          s_axi_awvalid, s_axi_awready, s_axi_arvalid, s_axi_arready;
  logic [DW-1:0] s_axi_wdata, s_axi_rdata;
  logic [MW-1:0] s_axi_wstrb;
  logic          s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [3:0]    s_axi_bid, s_axi_rid;
  logic [1:0]    s_axi_bresp, s_axi_rresp;
  logic          s_axi_bvalid, s_axi_bready;
  logic          s_axi_rlast, s_axi_rvalid, s_axi_rready;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: word contents plus which bytes have ever been written.
  logic [DW-1:0] mdl_data  [DEPTH];
  logic [MW-1:0] mdl_known [DEPTH];
  logic [DW-1:0] beat_data [256];
  logic [MW-1:0] beat_strb [256];

  logic [145:0] all_out;
  assign all_out = {s_axi_awready, s_axi_wready, s_axi_bid, s_axi_bresp, s_axi_bvalid,
                    s_axi_arready, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast,
                    s_axi_rvalid};

  always #5 clk = ~clk;

  axi_mem_responder dut (
    .i_clk(clk), .i_rst_x(rst_x),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [AW-1:0] addr, input int beat);
    return (int'(addr >> 4) + beat) % DEPTH;
  endfunction

  function automatic logic [DW-1:0] strb_mask(input logic [MW-1:0] s);
    logic [DW-1:0] m;
    for (int k = 0; k < MW; k++) m[k*8 +: 8] = {8{s[k]}};
    return m;
  endfunction

  function automatic void model_write(input logic [AW-1:0] addr, input int beat,
                                      input logic [DW-1:0] data, input logic [MW-1:0] strb);
    int            j;
    logic [DW-1:0] m;
    j = word_of(addr, beat);
    m = strb_mask(strb);
    mdl_data[j]  = (mdl_data[j] & ~m) | (data & m);
    mdl_known[j] = mdl_known[j] | strb;
  endfunction

  task automatic send_aw(input logic [3:0] id, input logic [AW-1:0] addr, input logic [7:0] len);
    int n = 0;
    @(negedge clk);
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
    s_axi_awsize = 3'($urandom); s_axi_awburst = 2'($urandom); s_axi_awlock = 1'($urandom);
    s_axi_awcache = 4'($urandom); s_axi_awprot = 3'($urandom); s_axi_awqos = 4'($urandom);
    s_axi_awvalid = 1'b1;
    #1;
    while (!s_axi_awready && n < 20) begin @(negedge clk); #1; n++; end
    check("aw_accept", s_axi_awready, 1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [AW-1:0] addr, input logic [7:0] len);
    int n = 0;
    @(negedge clk);
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = 3'($urandom); s_axi_arburst = 2'($urandom); s_axi_arlock = 1'($urandom);
    s_axi_arcache = 4'($urandom); s_axi_arprot = 3'($urandom); s_axi_arqos = 4'($urandom);
    s_axi_arvalid = 1'b1;
    #1;
    while (!s_axi_arready && n < 20) begin @(negedge clk); #1; n++; end
    check("ar_accept", s_axi_arready, 1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
  endtask

  // W beats from beat_data/beat_strb, then the B response. bad_beat >= 0 puts
  // wlast on that beat only; the expected bresp follows from where wlast fell.
  task automatic w_phase(input logic [3:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                         input int bad_beat, input int bstall);
    logic       err = 1'b0;
    logic [1:0] exp_resp;
    for (int i = 0; i <= int'(len); i++) begin
      s_axi_wdata = beat_data[i];
      s_axi_wstrb = beat_strb[i];
      s_axi_wlast = (bad_beat >= 0) ? (i == bad_beat) : (i == int'(len));
      if (s_axi_wlast != (i == int'(len))) err = 1'b1;
      s_axi_wvalid = 1'b1;
      #1;
      check("wready", s_axi_wready, 1);
      model_write(addr, i, beat_data[i], beat_strb[i]);
      @(negedge clk);
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    #1;
    check("bvalid_rise", s_axi_bvalid, 1);
    check("no_extra_w", s_axi_wready, 0);
    repeat (bstall) begin
      @(negedge clk); #1;
      check("bvalid_hold", s_axi_bvalid, 1);
    end
    exp_resp = err ? 2'b10 : 2'b00;
    s_axi_bready = 1'b1;
    check("bid", s_axi_bid, id);
    check("bresp", s_axi_bresp, exp_resp);
    @(negedge clk);
    s_axi_bready = 1'b0;
    #1;
    check("b_done", s_axi_bvalid, 0);
  endtask

  // R beats: rvalid two cycles after each address/data handshake, rdata held
  // through stall cycles; only bytes the model has seen written are compared.
  task automatic r_phase(input logic [3:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                         input int stall);
    logic [DW-1:0] m, e;
    int            j, d;
    #1;
    check("r_gap", s_axi_rvalid, 0);
    for (int i = 0; i <= int'(len); i++) begin
      j = word_of(addr, i);
      m = strb_mask(mdl_known[j]);
      e = mdl_data[j] & m;
      @(negedge clk); #1;
      check("rvalid", s_axi_rvalid, 1);
      check("rdata", s_axi_rdata & m, e);
      d = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
      repeat (d) begin
        @(negedge clk); #1;
        check("rvalid_hold", s_axi_rvalid, 1);
        check("rdata_hold", s_axi_rdata & m, e);
      end
      s_axi_rready = 1'b1;
      check("rlast", s_axi_rlast, (i == int'(len)));
      check("rid", s_axi_rid, id);
      check("rresp", s_axi_rresp, 2'b00);
      @(negedge clk);
      s_axi_rready = 1'b0;
      #1;
      check("r_gap", s_axi_rvalid, 0);
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input int bad_beat, input int bstall);
    send_aw(id, addr, len);
    w_phase(id, addr, len, bad_beat, bstall);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                         input int stall);
    send_ar(id, addr, len);
    r_phase(id, addr, len, stall);
  endtask

  task automatic fill_beats(input int n);
    for (int i = 0; i < n; i++) begin
      beat_data[i] = {$urandom, $urandom, $urandom, $urandom};
      beat_strb[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] addr;
    logic [7:0]    len;
    int            bad;

    rst_x = 1'b0;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
    s_axi_awlock = 1'b0; s_axi_awcache = '0; s_axi_awprot = '0; s_axi_awqos = '0;
    s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0;
    s_axi_arlock = 1'b0; s_axi_arcache = '0; s_axi_arprot = '0; s_axi_arqos = '0;
    s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin mdl_data[i] = '0; mdl_known[i] = '0; end

    // Reset values, and readies held low during reset even with requests up.
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", all_out, 0);
    s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
    #1;
    check("ready_in_reset", {s_axi_awready, s_axi_arready}, 2'b00);
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    @(negedge clk);
    rst_x = 1'b1;

    // Arbitration: write wins the first tie after reset, read wins the next.
    fill_beats(1);
    @(negedge clk);
    s_axi_awid = 4'h3; s_axi_awaddr = 28'h100; s_axi_awlen = 8'd0; s_axi_awvalid = 1'b1;
    s_axi_arid = 4'h5; s_axi_araddr = 28'h100; s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1;
    #1;
    check("arb_w_first", {s_axi_awready, s_axi_arready}, 2'b10);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    #1;
    check("arb_ar_waits", s_axi_arready, 0);
    w_phase(4'h3, 28'h100, 8'd0, -1, 0);
    s_axi_awid = 4'h6; s_axi_awaddr = 28'h110; s_axi_awvalid = 1'b1;
    #1;
    check("arb_r_second", {s_axi_awready, s_axi_arready}, 2'b01);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    r_phase(4'h5, 28'h100, 8'd0, -1);
    check("arb_w_after_r", s_axi_awready, 1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    fill_beats(1);
    w_phase(4'h6, 28'h110, 8'd0, -1, 1);

    // Single write then read at 0x40.
    beat_data[0] = 128'h0123456789ABCDEF_0123456789ABCDEF;
    beat_strb[0] = 16'hFFFF;
    do_write(4'h9, 28'h40, 8'd0, -1, 0);
    do_read(4'h2, 28'h40, 8'd0, 0);

    // Byte strobes on word 5: all ones, then zero the low four bytes.
    beat_data[0] = '1;
    beat_strb[0] = 16'hFFFF;
    do_write(4'h1, 28'h50, 8'd0, -1, 0);
    beat_data[0] = '0;
    beat_strb[0] = 16'h000F;
    do_write(4'h1, 28'h50, 8'd0, -1, 0);
    do_read(4'h1, 28'h50, 8'd0, -1);

    // Four beats starting two words below the top: beats 3 and 4 wrap to 0 and 1.
    fill_beats(4);
    for (int i = 0; i < 4; i++) beat_strb[i] = 16'hFFFF;
    do_write(4'h2, 28'hA5FFE0, 8'd3, -1, 0);
    do_read(4'h2, 28'hA5FFE0, 8'd3, -1);
    do_read(4'h7, 28'h0000000, 8'd1, 0);

    // wlast on the first of two beats: both beats land, response is SLVERR;
    // the next clean write must report OKAY again.
    fill_beats(2);
    do_write(4'h4, 28'h200, 8'd1, 0, 0);
    do_read(4'h4, 28'h200, 8'd1, -1);
    fill_beats(1);
    do_write(4'h4, 28'h220, 8'd0, -1, 0);

    // Read backpressure: rready held low for five cycles.
    do_read(4'h3, 28'h40, 8'd0, 5);

    // Reset during a write burst after three of eight beats.
    send_aw(4'h8, 28'h300, 8'd7);
    for (int i = 0; i < 3; i++) begin
      s_axi_wdata = {$urandom, $urandom, $urandom, $urandom};
      s_axi_wstrb = 16'hFFFF;
      s_axi_wlast = 1'b0;
      s_axi_wvalid = 1'b1;
      model_write(28'h300, i, s_axi_wdata, s_axi_wstrb);
      @(negedge clk);
    end
    #2;
    rst_x = 1'b0;
    #1;
    check("rst_mid_write", all_out, 0);
    s_axi_wvalid = 1'b0;
    @(negedge clk);
    rst_x = 1'b1;
    do_read(4'h8, 28'h300, 8'd2, -1);

    // Reset while a read beat is being presented.
    send_ar(4'h9, 28'h300, 8'd2);
    @(negedge clk); #1;
    check("rvalid_before_rst", s_axi_rvalid, 1);
    #1;
    rst_x = 1'b0;
    #1;
    check("rst_mid_read", all_out, 0);
    @(negedge clk);
    rst_x = 1'b1;

    // Randomized bursts, each read back with random low address bits.
    for (int t = 0; t < 30; t++) begin
      len  = 8'($urandom_range(0, 7));
      addr = 28'($urandom);
      fill_beats(int'(len) + 1);
      bad  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, int'(len))) : -1;
      do_write(4'($urandom), addr, len, bad, int'($urandom_range(0, 2)));
      do_read(4'($urandom), {addr[AW-1:4], 4'($urandom)}, len, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
